mem_stage: RTL

//  Consumer end of the execute-stage output interface (result/address, store data).

---
 rtl/mem_stage.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage - EX/MEM pipeline register, data-memory req/ready handshake, store lane steering, load extension.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_stage #(
  parameter int WORD_SIZE      = 32,
  parameter int NUM_REGS       = 32,
  parameter int REG_SEL        = $clog2(NUM_REGS),
  parameter int DMEM_ADDR_SIZE = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  input  logic [WORD_SIZE-1:0]      ex_result,
  input  logic [WORD_SIZE-1:0]      ex_write_data,
  input  logic [REG_SEL-1:0]        ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic [2:0]                ex_funct3,
  output logic                      stall,
  output logic [WORD_SIZE-1:0]      mem_forward,
  output logic [REG_SEL-1:0]        mem_fwd_rd,
  output logic                      mem_fwd_we,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [DMEM_ADDR_SIZE-1:0] dmem_addr,
  output logic [3:0]                dmem_be,
  output logic [WORD_SIZE-1:0]      dmem_wdata,
  input  logic                      dmem_ready,
  input  logic [WORD_SIZE-1:0]      dmem_rdata,
  output logic                      wb_valid,
  output logic                      wb_reg_write,
  output logic [REG_SEL-1:0]        wb_rd,
  output logic [WORD_SIZE-1:0]      wb_data,
  output logic                      misalign_fault
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]           state_q, state_d;
  logic                 m_valid_q, m_valid_d;
  logic [WORD_SIZE-1:0] m_result_q, m_result_d;
  logic [WORD_SIZE-1:0] m_wdata_q, m_wdata_d;
  logic [REG_SEL-1:0]   m_rd_q, m_rd_d;
  logic                 m_reg_write_q, m_reg_write_d;
  logic                 m_load_q, m_load_d;
  logic                 m_store_q, m_store_d;
  logic [2:0]           m_funct3_q, m_funct3_d;
  logic                 m_misalign_q, m_misalign_d;
  logic                 wb_valid_q, wb_valid_d;
  logic                 wb_reg_write_q, wb_reg_write_d;
  logic [REG_SEL-1:0]   wb_rd_q, wb_rd_d;
  logic [WORD_SIZE-1:0] wb_data_q, wb_data_d;
  logic                 fault_q, fault_d;

  logic                 ex_mem_op;
  logic                 ex_misalign;
  logic                 in_access;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [WORD_SIZE-1:0] ld_ext;
  logic [3:0]           st_be;
  logic [WORD_SIZE-1:0] st_wdata;

`ifdef MISALIGN_TRAP_EN
  // funct3[1:0] = 01 is a halfword; funct3[1] = 1 covers W and the reserved encodings treated as W.
  assign ex_misalign = ((ex_funct3[1:0] == 2'b01) && ex_result[0]) ||
                       (ex_funct3[1] && (ex_result[1:0] != 2'b00));
`else
  assign ex_misalign = 1'b0;
`endif

  assign in_access = (state_q == ST_ACCESS);
  assign ex_mem_op = ex_valid && (ex_mem_read || ex_mem_write);

  always_comb begin
    stall = in_access && !dmem_ready;

    state_d       = state_q;
    m_valid_d     = m_valid_q;
    m_result_d    = m_result_q;
    m_wdata_d     = m_wdata_q;
    m_rd_d        = m_rd_q;
    m_reg_write_d = m_reg_write_q;
    m_load_d      = m_load_q;
    m_store_d     = m_store_q;
    m_funct3_d    = m_funct3_q;
    m_misalign_d  = m_misalign_q;
    if (!stall) begin
      m_valid_d     = ex_valid;
      m_result_d    = ex_result;
      m_wdata_d     = ex_write_data;
      m_rd_d        = ex_rd;
      m_reg_write_d = ex_valid && ex_reg_write;
      m_load_d      = ex_valid && ex_mem_read;
      m_store_d     = ex_valid && ex_mem_write && !ex_mem_read;
      m_funct3_d    = ex_funct3;
      m_misalign_d  = ex_mem_op && ex_misalign;
      state_d       = (ex_mem_op && !ex_misalign) ? ST_ACCESS : ST_IDLE;
    end
  end

  always_comb begin
    case (m_result_q[1:0])
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = m_result_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (m_funct3_q)
      3'b000:  ld_ext = {{(WORD_SIZE-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {{(WORD_SIZE-8){1'b0}}, ld_byte};
      3'b001:  ld_ext = {{(WORD_SIZE-16){ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {{(WORD_SIZE-16){1'b0}}, ld_half};
      default: ld_ext = dmem_rdata;
    endcase

    case (m_funct3_q[1:0])
      2'b00: begin
        st_be    = 4'b0001 << m_result_q[1:0];
        st_wdata = {(WORD_SIZE/8){m_wdata_q[7:0]}};
      end
      2'b01: begin
        st_be    = m_result_q[1] ? 4'b1100 : 4'b0011;
        st_wdata = {(WORD_SIZE/16){m_wdata_q[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = m_wdata_q;
      end
    endcase
  end

  always_comb begin
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    fault_d        = 1'b0;
    if (in_access) begin
      if (dmem_ready) begin
        wb_valid_d     = 1'b1;
        wb_reg_write_d = m_load_q && m_reg_write_q;
        wb_rd_d        = m_rd_q;
        wb_data_d      = m_load_q ? ld_ext : m_result_q;
      end
    end else if (m_valid_q) begin
      // Non-memory ops and trapped misaligned accesses retire straight from M.
      wb_valid_d     = 1'b1;
      wb_reg_write_d = m_reg_write_q && !m_misalign_q;
      wb_rd_d        = m_rd_q;
      wb_data_d      = m_result_q;
      fault_d        = m_misalign_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      m_valid_q      <= 1'b0;
      m_result_q     <= '0;
      m_wdata_q      <= '0;
      m_rd_q         <= '0;
      m_reg_write_q  <= 1'b0;
      m_load_q       <= 1'b0;
      m_store_q      <= 1'b0;
      m_funct3_q     <= 3'b000;
      m_misalign_q   <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      m_valid_q      <= m_valid_d;
      m_result_q     <= m_result_d;
      m_wdata_q      <= m_wdata_d;
      m_rd_q         <= m_rd_d;
      m_reg_write_q  <= m_reg_write_d;
      m_load_q       <= m_load_d;
      m_store_q      <= m_store_d;
      m_funct3_q     <= m_funct3_d;
      m_misalign_q   <= m_misalign_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      fault_q        <= fault_d;
    end
  end

  assign mem_forward    = m_result_q;
  assign mem_fwd_rd     = m_rd_q;
  assign mem_fwd_we     = m_valid_q && m_reg_write_q && !m_load_q;
  assign dmem_req       = in_access;
  assign dmem_we        = in_access && m_store_q;
  assign dmem_addr      = m_result_q[DMEM_ADDR_SIZE+1:2];
  assign dmem_be        = (in_access && m_store_q) ? st_be : 4'b0000;
  assign dmem_wdata     = st_wdata;
  assign wb_valid       = wb_valid_q;
  assign wb_reg_write   = wb_reg_write_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign misalign_fault = fault_q;

endmodule
